// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu (ops 7..10).
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB, ACC_NONE} acc_t;

  state_t state, state_nx;
  acc_t   acc, acc_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] temp;
  logic               is_mul, is_div, is_sgn;
  logic               do_mthi, do_mtlo;
  logic               go, launch, last;

  logic [2*WIDTH-1:0] sa, sb, ua, ub, prod, res;
  logic [WIDTH-1:0]   dvs, quo, rem;
  logic signed [WIDTH-1:0] sq, sr;
  logic               ovf;

  // Decode the opcode into operation class and commit mode
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    do_mthi = 1'b0;
    do_mtlo = 1'b0;
    acc_nx  = ACC_SET;
    case (op)
      4'd1: begin is_mul = 1'b1; is_sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; is_sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      4'd5: do_mthi = 1'b1;
      4'd6: do_mtlo = 1'b1;
`ifdef MD_MADD_EN
      4'd7: begin is_mul = 1'b1; is_sgn = 1'b1; acc_nx = ACC_ADD; end
      4'd8: begin is_mul = 1'b1; acc_nx = ACC_ADD; end
      4'd9: begin is_mul = 1'b1; is_sgn = 1'b1; acc_nx = ACC_SUB; end
      4'd10: begin is_mul = 1'b1; acc_nx = ACC_SUB; end
`endif
      default: ;
    endcase
    if (is_div && B == ZERO) acc_nx = ACC_NONE;
  end

  // Product and quotient/remainder of the sampled operands
  always_comb begin
    sa   = {{WIDTH{A[WIDTH-1]}}, A};
    sb   = {{WIDTH{B[WIDTH-1]}}, B};
    ua   = {ZERO, A};
    ub   = {ZERO, B};
    prod = is_sgn ? sa * sb : ua * ub;
    // -MIN/-1 overflows; dividing by 1 yields exactly LO=A, HI=0.
    ovf  = is_sgn && A == SMIN && B == '1;
    dvs  = (B == ZERO || ovf) ? ONE : B;
    sq   = $signed(A) / $signed(dvs);
    sr   = $signed(A) % $signed(dvs);
    quo  = is_sgn ? sq : A / dvs;
    rem  = is_sgn ? sr : A % dvs;
    res  = is_mul ? prod : {rem, quo};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (launch) state_nx = RUN;
      RUN:  if (last)   state_nx = IDLE;
    endcase
  end

  // FSM outputs and launch/commit strobes
  always_comb begin
    busy   = (state == RUN);
    go     = start && !busy;
    launch = go && (is_mul || is_div);
    last   = busy && cnt == CW'(1);
  end

  // Capture the pending result and run the latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      temp <= '0;
      acc  <= ACC_SET;
    end else if (launch) begin
      cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      temp <= res;
      acc  <= acc_nx;
    end else if (busy) begin
      cnt  <= cnt - CW'(1);
    end
  end

  // HI/LO: commit pending result or direct move
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (last) begin
      unique case (acc)
        ACC_SET:  {HI, LO} <= temp;
        ACC_ADD:  {HI, LO} <= {HI, LO} + temp;
        ACC_SUB:  {HI, LO} <= {HI, LO} - temp;
        ACC_NONE: ;
      endcase
    end else if (go && do_mthi) begin
      HI <= A;
    end else if (go && do_mtlo) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Expectations follow MD_MADD_EN the same way the design does.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;
  logic        probe = 1'b0;

  always #5 clk = ~clk;

  md_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .A(A),
    .B(B),
    .busy(busy),
    .HI(HI),
    .LO(LO)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   run = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop on busy falling edge (multi-cycle) or probe (single-cycle)
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
      run = 0;
    end else begin
      if (busy) run++;
      if ((prev_busy && !busy) || probe) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got result, expected none");
        end else begin
          e = sbq.pop_front();
          check({e.name, "_hi"}, HI, e.hi);
          check({e.name, "_lo"}, LO, e.lo);
          check({e.name, "_busy_len"}, 32'(run), 32'(e.len));
        end
        run = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1, expected 0", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic single(input string name, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    sbq.push_back('{name, ehi, elo, 0});
    issue(o, a, b);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic multi(input string name, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input int len);
    sbq.push_back('{name, ehi, elo, len});
    issue(o, a, b);
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset in the middle of a divide
    single("pre_mthi", 4'd5, 32'h12345678, 32'h0, 32'h12345678, 32'h0);
    single("pre_mtlo", 4'd6, 32'h12345678, 32'h0,
           32'h12345678, 32'h12345678);
    issue(4'd3, 32'd100, 32'd7);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);
    check("post_abort_hi", HI, 32'h0);
    check("post_abort_lo", LO, 32'h0);
    @(posedge clk); #1;

    // Multiply
    multi("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    multi("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5);

    // Divide
    multi("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    multi("divu", 4'd4, 32'd7, 32'd2, 32'h1, 32'h3, 10);
    multi("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);
    multi("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF,
          32'h0, 32'h80000000, 10);

    // Divide by zero, with a start pulse ignored while busy
    single("set_hi5", 4'd5, 32'd5, 32'h0, 32'h5, 32'h80000000);
    single("set_lo9", 4'd6, 32'd9, 32'h0, 32'h5, 32'h9);
    sbq.push_back('{"div0", 32'h5, 32'h9, 10});
    issue(4'd3, 32'd123, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = '0;
    wait_idle("div0");

    // Direct moves and no-op codes
    single("mthi", 4'd5, 32'hAAAA0000, 32'h0, 32'hAAAA0000, 32'h9);
    single("mtlo", 4'd6, 32'h5555, 32'h0, 32'hAAAA0000, 32'h5555);
    single("op0", 4'd0, 32'h1, 32'h1, 32'hAAAA0000, 32'h5555);
    single("op15", 4'd15, 32'h1, 32'h1, 32'hAAAA0000, 32'h5555);

    // Multiply-accumulate family
    single("acc_hi0", 4'd5, 32'h0, 32'h0, 32'h0, 32'h5555);
    single("acc_lo", 4'd6, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
    multi("madd", 4'd7, 32'd1, 32'd1, 32'h1, 32'h0, 5);
    multi("msub", 4'd9, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 5);
`else
    single("madd_off", 4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF);
    single("msubu_off", 4'd10, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF);
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
